// File: rtl/char_buffer_scroll.sv
// rtl/char_buffer_scroll.sv - text-mode character buffer with terminal write engine and row-offset scrolling
// Writes are posted one cycle after the FSM decides them, so a read issued alongside a command sees old data.
module char_buffer_scroll #(
    parameter int                COLS   = 80,
    parameter int                ROWS   = 25,
    parameter int                DATA_W = 8,
    parameter logic [DATA_W-1:0] BLANK  = 8'h20
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [1:0]                cmd_op,
    input  logic [DATA_W-1:0]         cmd_data,
    output logic [$clog2(COLS)-1:0]   cursor_col,
    output logic [$clog2(ROWS)-1:0]   cursor_row,
    output logic                      busy,
    input  logic [$clog2(ROWS)-1:0]   rd_row,
    input  logic [$clog2(COLS)-1:0]   rd_col,
    output logic [DATA_W-1:0]         rd_data
);
    localparam int CW    = $clog2(COLS);
    localparam int RW    = $clog2(ROWS);
    localparam int CELLS = COLS * ROWS;
    localparam int AW    = $clog2(CELLS);

    localparam logic [1:0] OP_PUT = 2'b00;
    localparam logic [1:0] OP_NL  = 2'b01;
    localparam logic [1:0] OP_CLR = 2'b10;
    localparam logic [1:0] OP_CR  = 2'b11;

    typedef enum logic [1:0] {CLR_ALL, IDLE, LINE_CLR} state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       cnt_q, cnt_d;
    logic [CW-1:0]       col_q, col_d;
    logic [RW-1:0]       row_q, row_d;
    logic [RW-1:0]       top_row_q, top_row_d;
    logic                wr_en_q, wr_en_d;
    logic [AW-1:0]       wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic [AW-1:0]       rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0]   rd_data_q;
    logic                do_nl;
    logic [RW-1:0]       bottom_row;

    logic [DATA_W-1:0]   mem [CELLS];

    // Sum is one bit wider than a row index so the wrap compare sees the carry.
    function automatic logic [RW-1:0] phys_row(input logic [RW-1:0] r, input logic [RW-1:0] t);
        logic [RW:0] s;
        s = {1'b0, r} + {1'b0, t};
        if (s >= (RW+1)'(ROWS))
            s = s - (RW+1)'(ROWS);
        return s[RW-1:0];
    endfunction

    function automatic logic [AW-1:0] addr_of(input logic [RW-1:0] r, input logic [CW-1:0] c);
        return AW'(r) * AW'(COLS) + AW'(c);
    endfunction

    assign bottom_row = (top_row_q == '0) ? RW'(ROWS - 1) : top_row_q - 1'b1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        col_d     = col_q;
        row_d     = row_q;
        top_row_d = top_row_q;
        wr_en_d   = 1'b0;
        wr_addr_d = cnt_q;
        wr_data_d = BLANK;
        do_nl     = 1'b0;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        case (state_q)
            CLR_ALL: begin
                wr_en_d = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == AW'(CELLS - 1)) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    col_d     = '0;
                    row_d     = '0;
                    top_row_d = '0;
                end
            end
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_PUT: begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = addr_of(phys_row(row_q, top_row_q), col_q);
                            wr_data_d = cmd_data;
                            if (col_q < CW'(COLS - 1))
                                col_d = col_q + 1'b1;
                            else
                                do_nl = 1'b1;
                        end
                        OP_NL: do_nl = 1'b1;
                        OP_CLR: begin
                            state_d = CLR_ALL;
                            cnt_d   = '0;
                        end
                        OP_CR: col_d = '0;
                        default: ;
                    endcase
                    if (do_nl) begin
                        col_d = '0;
                        if (row_q < RW'(ROWS - 1)) begin
                            row_d = row_q + 1'b1;
                        end else begin
                            top_row_d = (top_row_q == RW'(ROWS - 1)) ? '0 : top_row_q + 1'b1;
                            state_d   = LINE_CLR;
                            cnt_d     = '0;
                        end
                    end
                end
            end
            LINE_CLR: begin
                // top_row has already advanced, so the old top line is now the bottom.
                wr_en_d   = 1'b1;
                wr_addr_d = addr_of(bottom_row, cnt_q[CW-1:0]);
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == AW'(COLS - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = CLR_ALL;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        rd_addr_d = addr_of(phys_row(rd_row, top_row_q), rd_col);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= CLR_ALL;
            cnt_q     <= '0;
            col_q     <= '0;
            row_q     <= '0;
            top_row_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            col_q     <= col_d;
            row_q     <= row_d;
            top_row_q <= top_row_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= mem[rd_addr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_q)
            mem[wr_addr_q] <= wr_data_q;
    end

    assign cursor_col = col_q;
    assign cursor_row = row_q;
    assign rd_data    = rd_data_q;
endmodule

// File: tb/tb_char_buffer_scroll.sv
// tb/tb_char_buffer_scroll.sv - directed self-checking bench for char_buffer_scroll
module tb_char_buffer_scroll;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_data = 8'h00;
    logic [6:0] cursor_col;
    logic [4:0] cursor_row;
    logic       busy;
    logic [4:0] rd_row = '0;
    logic [6:0] rd_col = '0;
    logic [7:0] rd_data;

    int errors = 0;
    int checks = 0;

    char_buffer_scroll dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cursor_col(cursor_col),
        .cursor_row(cursor_row), .busy(busy), .rd_row(rd_row), .rd_col(rd_col),
        .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!cmd_ready && n < 5000) begin
            tick();
            n++;
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] d, output int waits);
        cmd_op    = op;
        cmd_data  = d;
        cmd_valid = 1'b1;
        wait_ready(waits);
        chk("send_ready", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic rd(input int r, input int c, output logic [7:0] d);
        rd_row = 5'(r);
        rd_col = 7'(c);
        tick();
        tick();
        d = rd_data;
    endtask

    initial begin
        int n;
        int nb;
        logic [7:0] d;

        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        chk("rst_col", 32'(cursor_col), 32'd0);
        chk("rst_row", 32'(cursor_row), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);

        rst = 1'b0;
        wait_ready(n);
        chk("init_clear_cycles", 32'(n), 32'd2000);
        chk("idle_busy", 32'(busy), 32'd0);
        rd(5, 17, d);
        chk("blank_5_17", 32'(d), 32'h20);
        rd(24, 79, d);
        chk("blank_24_79", 32'(d), 32'h20);

        // Read address presented in the same cycle the PUT is accepted.
        rd_row = 5'd0;
        rd_col = 7'd0;
        send(2'b00, 8'h41, n);
        tick();
        chk("rdw_old", 32'(rd_data), 32'h20);
        tick();
        chk("rdw_next_new", 32'(rd_data), 32'h41);
        send(2'b00, 8'h42, n);
        chk("ab_col", 32'(cursor_col), 32'd2);
        chk("ab_row", 32'(cursor_row), 32'd0);
        rd(0, 0, d);
        chk("rd_0_0_A", 32'(d), 32'h41);
        rd(0, 1, d);
        chk("rd_0_1_B", 32'(d), 32'h42);

        send(2'b11, 8'h00, n);
        chk("cr_col", 32'(cursor_col), 32'd0);
        for (int i = 0; i < 80; i++)
            send(2'b00, 8'(8'h30 + i % 10), n);
        chk("wrap_col", 32'(cursor_col), 32'd0);
        chk("wrap_row", 32'(cursor_row), 32'd1);
        rd(0, 79, d);
        chk("rd_0_79", 32'(d), 32'h39);
        rd(0, 0, d);
        chk("rd_0_0_ovw", 32'(d), 32'h30);
        for (int i = 0; i < 3; i++)
            send(2'b00, 8'h55, n);
        chk("three_col", 32'(cursor_col), 32'd3);
        send(2'b11, 8'h00, n);
        chk("cr2_col", 32'(cursor_col), 32'd0);
        chk("cr2_row", 32'(cursor_row), 32'd1);

        send(2'b10, 8'h00, n);
        wait_ready(n);
        chk("clear_cycles", 32'(n), 32'd2000);
        chk("clear_row", 32'(cursor_row), 32'd0);
        for (int r = 0; r < 25; r++) begin
            send(2'b00, 8'(r), n);
            if (r < 24)
                send(2'b01, 8'h00, n);
        end
        chk("fill_row", 32'(cursor_row), 32'd24);
        send(2'b01, 8'h00, n);
        chk("scroll_busy", 32'(busy), 32'd1);
        chk("scroll_nready", 32'(cmd_ready), 32'd0);
        wait_ready(n);
        chk("line_clr_cycles", 32'(n), 32'd80);
        rd(0, 0, d);
        chk("scr_rd_0_0", 32'(d), 32'd1);
        rd(23, 0, d);
        chk("scr_rd_23_0", 32'(d), 32'd24);
        nb = 0;
        for (int c = 0; c < 80; c++) begin
            rd(24, c, d);
            if (d !== 8'h20)
                nb++;
        end
        chk("scr_row24_nonblank", 32'(nb), 32'd0);
        chk("scr_cur_row", 32'(cursor_row), 32'd24);
        chk("scr_cur_col", 32'(cursor_col), 32'd0);

        for (int k = 0; k < 30; k++) begin
            send(2'b00, 8'(8'h80 + k), n);
            send(2'b01, 8'h00, n);
        end
        wait_ready(n);
        rd(23, 0, d);
        chk("wrap_rd_23", 32'(d), 32'h9d);
        rd(12, 0, d);
        chk("wrap_rd_12", 32'(d), 32'h92);
        rd(0, 0, d);
        chk("wrap_rd_0", 32'(d), 32'h86);
        rd(24, 0, d);
        chk("wrap_rd_24", 32'(d), 32'h20);

        send(2'b01, 8'h00, n);
        send(2'b10, 8'h00, n);
        chk("clr_held_waits", 32'(n), 32'd80);
        chk("clr_busy", 32'(busy), 32'd1);
        wait_ready(n);
        chk("clr2_cycles", 32'(n), 32'd2000);
        chk("clr2_row", 32'(cursor_row), 32'd0);
        chk("clr2_col", 32'(cursor_col), 32'd0);
        rd(23, 0, d);
        chk("clr2_rd_23", 32'(d), 32'h20);

        send(2'b00, 8'h41, n);
        send(2'b00, 8'h42, n);
        rd(0, 0, d);
        chk("pre_rst_rd", 32'(rd_data), 32'h41);
        send(2'b10, 8'h00, n);
        for (int i = 0; i < 50; i++)
            tick();
        chk("midclr_col_kept", 32'(cursor_col), 32'd2);
        rst = 1'b1;
        #2;
        chk("async_rd_data", 32'(rd_data), 32'd0);
        chk("async_col", 32'(cursor_col), 32'd0);
        chk("async_busy", 32'(busy), 32'd1);
        chk("async_ready", 32'(cmd_ready), 32'd0);
        tick();
        rst = 1'b0;
        wait_ready(n);
        chk("post_rst_cycles", 32'(n), 32'd2000);
        rd(0, 0, d);
        chk("post_rst_rd", 32'(d), 32'h20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/char_buffer_scroll.md
Name: char_buffer_scroll

Overview:
- Parametrised text-mode character buffer that adds a terminal-style write engine to a plain dual-port char RAM.
- Commands (put char, newline, carriage return, clear screen) arrive on a valid/ready port.
- A row-offset register gives hardware scrolling without copying memory.
- The video side reads by logical (row, col); the block translates to the physical address internally and returns data after a fixed 2-cycle latency.

Parameters:
- COLS, 80, characters per line
- ROWS, 25, lines on screen
- DATA_W, 8, bits per character cell
- BLANK, 8'h20, fill value used by clear operations (DATA_W wide)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command this cycle
- cmd_op  in  2  00 PUT, 01 NEWLINE, 10 CLEAR, 11 CR
- cmd_data  in  DATA_W  character for PUT (ignored otherwise)
- cursor_col  out  clog2(COLS)  current logical column
- cursor_row  out  clog2(ROWS)  current logical row
- busy  out  1  a multi-cycle clear is in progress
- rd_row  in  clog2(ROWS)  logical read row
- rd_col  in  clog2(COLS)  read column
- rd_data  out  DATA_W  cell contents, 2 cycles after address

Behaviour:
- Clock and reset: single clock `clk`; reset `rst` is asynchronous and active-high.
- Storage: COLS*ROWS x DATA_W RAM with one write port owned by the FSM and one independent read port. RAM has no reset.
- Physical address: `top_row` is a register in 0..ROWS-1.
  - phys_row = (logical_row + top_row), minus ROWS if the sum is >= ROWS.
  - addr = phys_row*COLS + col.
- Read pipeline:
  - Stage 1 registers the translated address.
  - Stage 2 registers the RAM output to rd_data.
  - Latency is exactly 2 cycles.
  - A read-during-write to the same cell returns the old data.
  - rd_row >= ROWS or rd_col >= COLS returns an undefined value; no other effect.
- Reset values: cursor_col=0, cursor_row=0, top_row=0, rd_data=0, cmd_ready=0, busy=1. FSM enters CLR_ALL with the fill counter at 0.
- FSM states:
  - CLR_ALL: writes BLANK to physical address = counter, one cell per cycle, for ROWS*COLS cycles. On the last cell it goes to IDLE with cursor=(0,0) and top_row=0.
  - IDLE: cmd_ready=1, busy=0. A command is accepted when cmd_valid && cmd_ready. Every accepted command completes its IDLE-cycle effects in that cycle.
  - LINE_CLR: writes BLANK to COLS cells of physical row top_row-1 (mod ROWS), i.e. the new bottom line. Takes COLS cycles, then returns to IDLE.
  - In CLR_ALL and LINE_CLR: cmd_ready=0, busy=1.
- PUT:
  - Writes cmd_data at the cursor.
  - If cursor_col < COLS-1: col increments.
  - Otherwise the write is followed by NEWLINE behaviour in the same cycle.
- NEWLINE:
  - col is set to 0.
  - If row < ROWS-1: row increments; stays in IDLE.
  - Otherwise (scroll): row is unchanged; top_row advances by 1 mod ROWS on the accept edge; FSM goes to LINE_CLR.
  - The scrolled-in line reads as stale data until LINE_CLR completes; this is acceptable.
- CR: col is set to 0; row is unchanged.
- CLR_ALL re-entry:
  - CLEAR enters CLR_ALL with counter 0.
  - Cursor and top_row are reset at the end of CLR_ALL, not the start.
- Width rules:
  - Counters and the phys_row sum are sized so no wrap occurs before the explicit compare.
  - ROWS*COLS need not be a power of 2.
- Reset mid-operation: asserting rst during LINE_CLR or CLR_ALL aborts the operation immediately. Deassertion restarts a full CLR_ALL.
- Commands presented while cmd_ready=0 are held by the source. They are neither dropped nor duplicated.

Test Plan (defaults: COLS=80, ROWS=25, BLANK=8'h20):
- Reset release -> busy=1 and cmd_ready=0 for exactly 2000 cycles, then cmd_ready=1. Reading any (row, col) gives 8'h20, with rd_data valid 2 cycles after the address.
- PUT 'A', PUT 'B' -> cursor (0,2). rd(0,0)=8'h41 and rd(0,1)=8'h42. A read issued the same cycle as the write to (0,0) returns 8'h20.
- 80 PUTs of 8'h30+i%10 starting at (0,0) -> cursor (1,0); rd(0,79)=8'h39. Then CR after 3 more PUTs -> cursor (1,0).
- Fill rows 0..24 with value r (24 NEWLINEs, each row marked at col 0), then NEWLINE on row 24:
  - busy=1 and cmd_ready=0 for 80 cycles.
  - Then rd(0,0)=1 and rd(23,0)=24; rd(24,0..79)=8'h20; cursor (24,0).
- Scroll 30 times (top_row wraps past 24) -> logical rows remain contiguous. The last-written line reads at row 23 (one line above the blank row 24); no corruption at the physical wrap.
- Assert cmd_valid with CLEAR during LINE_CLR -> it is accepted only after the 80 fill cycles finish. The subsequent 2000-cycle clear ends with cursor (0,0). rst asserted mid-clear -> outputs take reset values asynchronously.
